// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU issue stage:
//   - seq_state_e : sequencer FSM states (IDLE/ISSUE/WAIT/WB)
//   - instr_t     : packed view of the 16-bit instruction word
//   - *_MSB/_LSB  : instruction field bit positions
//   - FLAG_*      : bit indices inside the latched 5-bit flag vector
package alu_seq_pkg;

    localparam int INSTR_W = 16;
    localparam int DATA_W  = 8;
    localparam int NUM_REGS = 8;
    localparam int FLAG_W  = 5;

    // Instruction field positions
    localparam int OPCODE_MSB     = 15;
    localparam int OPCODE_LSB     = 11;
    localparam int RD_MSB         = 10;
    localparam int RD_LSB         = 8;
    localparam int RA_MSB         = 7;
    localparam int RA_LSB         = 5;
    localparam int RB_MSB         = 4;
    localparam int RB_LSB         = 2;
    localparam int USE_CARRY_BIT  = 1;
    localparam int USE_BORROW_BIT = 0;

    // Flag vector layout: {overflow, negative, zero, borrow, carry}
    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_BORROW   = 1;
    localparam int FLAG_ZERO     = 2;
    localparam int FLAG_NEGATIVE = 3;
    localparam int FLAG_OVERFLOW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } seq_state_e;

    // Field order matches the bit positions above, MSB first
    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       use_carry;
        logic       use_borrow;
    } instr_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo
// Synchronous instruction FIFO, WIDTH bits x DEPTH entries (DEPTH a power of 2).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   push, push_data     : write request and data (ignored when full)
//   pop, pop_data       : read request (ignored when empty); pop_data shows the head
//   full, empty, count  : occupancy, all derived from the registered count
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop frees a slot in the same cycle
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Issue stage for the 8-bit ALU: buffers instructions, reads operands from an
// 8x8 register file, hands them to the ALU, waits for the result (with timeout),
// writes the result back and latches the ALU flags for carry/borrow chaining.
// Ports:
//   clk, rst                           : clock, asynchronous active-low reset
//   instr_valid/instr_ready/instr_data : instruction push handshake
//   wr_en, wr_addr, wr_data            : host register preload
//   rd_addr, rd_data                   : combinational debug read
//   alu_*  (out)                       : enable, opcode, operands, input_ready, carry/borrow in
//   alu_*  (in)                        : result, result_ready and the five ALU flags
//   flags                              : latched {overflow, negative, zero, borrow, carry}
//   busy                               : FSM active or instructions pending
//   timeout_err                        : sticky, set when the ALU never answers
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr_data,
    input  logic          wr_en,
    input  logic [2:0]    wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [2:0]    rd_addr,
    output logic [7:0]    rd_data,
    output logic          alu_enable,
    output logic [4:0]    alu_opcode,
    output logic [7:0]    alu_operand_A,
    output logic [7:0]    alu_operand_B,
    output logic          alu_input_ready,
    output logic          alu_carry_in,
    output logic          alu_borrow_in,
    input  logic [7:0]    alu_result,
    input  logic          alu_result_ready,
    input  logic          alu_carry_out,
    input  logic          alu_borrow_out,
    input  logic          alu_zero,
    input  logic          alu_negative,
    input  logic          alu_overflow,
    output logic [4:0]    flags,
    output logic          busy,
    output logic          timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [INSTR_W-1:0]       fifo_data;
    instr_t                   head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;

    logic                     load_op;
    logic                     cnt_clear;
    logic                     cnt_inc;
    logic                     capture_result;
    logic                     set_timeout;
    logic                     write_back;

    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [2:0]               rd_q;
    logic [CNT_W-1:0]         wait_cnt;
    logic [DATA_W-1:0]        result_q;
    logic [FLAG_W-1:0]        flags_cap;
    logic [FLAG_W-1:0]        flags_q;

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (instr_valid),
        .push_data (instr_data),
        .pop       (load_op),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head        = fifo_data;
    assign instr_ready = !fifo_full;
    assign busy        = (state_q != IDLE) || (fifo_count != '0);
    assign rd_data     = regs[rd_addr];
    assign flags       = flags_q;
    // Reset is asynchronous, so the enable drops immediately while rst is low
    assign alu_enable  = rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // result_ready only matters in WAIT; the timeout fires on the TIMEOUT-th
    // WAIT cycle, so the counter never needs to exceed TIMEOUT-1
    always_comb begin
        state_d         = state_q;
        load_op         = 1'b0;
        cnt_clear       = 1'b0;
        cnt_inc         = 1'b0;
        capture_result  = 1'b0;
        set_timeout     = 1'b0;
        write_back      = 1'b0;
        alu_input_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load_op = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                alu_input_ready = 1'b1;
                cnt_clear       = 1'b1;
                state_d         = WAIT;
            end
            WAIT: begin
                if (alu_result_ready) begin
                    capture_result = 1'b1;
                    state_d        = WB;
                end else if (wait_cnt == LAST_WAIT) begin
                    set_timeout = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WB: begin
                write_back = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands and carry/borrow-in are snapshotted at the pop, so later host
    // writes or flag updates cannot disturb an instruction already in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_opcode    <= '0;
            alu_operand_A <= '0;
            alu_operand_B <= '0;
            alu_carry_in  <= 1'b0;
            alu_borrow_in <= 1'b0;
            rd_q          <= '0;
            wait_cnt      <= '0;
            result_q      <= '0;
            flags_cap     <= '0;
            flags_q       <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if (load_op) begin
                alu_opcode    <= head.opcode;
                alu_operand_A <= regs[head.ra];
                alu_operand_B <= regs[head.rb];
                alu_carry_in  <= head.use_carry & flags_q[FLAG_CARRY];
                alu_borrow_in <= head.use_borrow & flags_q[FLAG_BORROW];
                rd_q          <= head.rd;
            end
            if (cnt_clear) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + CNT_ONE;
            end
            if (capture_result) begin
                result_q                 <= alu_result;
                flags_cap[FLAG_CARRY]    <= alu_carry_out;
                flags_cap[FLAG_BORROW]   <= alu_borrow_out;
                flags_cap[FLAG_ZERO]     <= alu_zero;
                flags_cap[FLAG_NEGATIVE] <= alu_negative;
                flags_cap[FLAG_OVERFLOW] <= alu_overflow;
            end
            if (write_back) begin
                flags_q <= flags_cap;
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Writeback has priority over a host write to the same register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (write_back && (rd_q == 3'(i))) begin
                    regs[i] <= result_q;
                end else if (wr_en && (wr_addr == 3'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. The bench plays the ALU itself and
// keeps a behavioural model: register array, flag vector, sticky timeout bit
// and a queue of accepted-but-not-yet-issued instructions.
module tb_alu_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        alu_enable;
    logic [4:0]  alu_opcode;
    logic [7:0]  alu_operand_A;
    logic [7:0]  alu_operand_B;
    logic        alu_input_ready;
    logic        alu_carry_in;
    logic        alu_borrow_in;
    logic [7:0]  alu_result;
    logic        alu_result_ready;
    logic        alu_carry_out;
    logic        alu_borrow_out;
    logic        alu_zero;
    logic        alu_negative;
    logic        alu_overflow;
    logic [4:0]  flags;
    logic        busy;
    logic        timeout_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  ref_regs [8];
    logic [4:0]  ref_flags;
    logic        ref_timeout;
    logic [15:0] q[$];
    logic [15:0] pend[$];

    always #5 clk = ~clk;

    alu_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .alu_enable       (alu_enable),
        .alu_opcode       (alu_opcode),
        .alu_operand_A    (alu_operand_A),
        .alu_operand_B    (alu_operand_B),
        .alu_input_ready  (alu_input_ready),
        .alu_carry_in     (alu_carry_in),
        .alu_borrow_in    (alu_borrow_in),
        .alu_result       (alu_result),
        .alu_result_ready (alu_result_ready),
        .alu_carry_out    (alu_carry_out),
        .alu_borrow_out   (alu_borrow_out),
        .alu_zero         (alu_zero),
        .alu_negative     (alu_negative),
        .alu_overflow     (alu_overflow),
        .flags            (flags),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic uc, input logic ub);
        return {op, rd, ra, rb, uc, ub};
    endfunction

    // Reference ALU: returns {overflow, negative, zero, borrow, carry, result}
    function automatic logic [12:0] alu_model(input logic [4:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic cin, input logic bin);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        logic       bo;
        logic       ov;
        c  = 1'b0;
        bo = 1'b0;
        ov = 1'b0;
        case (op)
            5'd0: begin
                s  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
                r  = s[7:0];
                c  = s[8];
                ov = (a[7] == b[7]) && (r[7] != a[7]);
            end
            5'd1: begin
                s  = {1'b0, a} - {1'b0, b} - {8'b0, bin};
                r  = s[7:0];
                bo = s[8];
                ov = (a[7] != b[7]) && (r[7] != a[7]);
            end
            default: r = a ^ b ^ {3'b0, op};
        endcase
        return {ov, r[7], (r == 8'h00), bo, c, r};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
        ref_flags   = 5'b0;
        ref_timeout = 1'b0;
        q.delete();
        pend.delete();
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check_output($sformatf("%s_r%0d", tag, i), {8'h00, rd_data}, {8'h00, ref_regs[i]});
        end
        check_output({tag, "_flags"}, {11'h0, flags}, {11'h0, ref_flags});
        check_output({tag, "_timeout"}, {15'h0, timeout_err}, {15'h0, ref_timeout});
    endtask

    task automatic preload(input logic [2:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
        ref_regs[addr] = data;
    endtask

    task automatic push_now(input logic [15:0] d);
        instr_data  = d;
        instr_valid = 1'b1;
        check_output("instr_ready", {15'h0, instr_ready}, {15'h0, (q.size() < DEPTH)});
        if (q.size() < DEPTH) q.push_back(d);
        tick();
        instr_valid = 1'b0;
    endtask

    // Offers the next pending instruction this cycle, regardless of instr_ready
    task automatic drive_push();
        logic [15:0] d;
        if (pend.size() > 0) begin
            d = pend.pop_front();
            instr_data  = d;
            instr_valid = 1'b1;
            check_output("instr_ready_fill", {15'h0, instr_ready}, {15'h0, (q.size() < DEPTH)});
            if (q.size() < DEPTH) q.push_back(d);
        end else begin
            instr_valid = 1'b0;
        end
    endtask

    // Acts as the ALU for the next issued instruction: answers in the k-th
    // WAIT cycle, or never when expect_to is set. Optionally collides a host
    // write with WB (collide) or overwrites ra right after the pop (ra_write).
    task automatic apply_stimulus(input int k, input bit expect_to, input bit collide, input bit ra_write);
        logic [15:0] ins;
        logic [4:0]  op;
        logic [2:0]  rd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic        bin;
        logic [12:0] m;
        int          n;
        n = 0;
        while (!alu_input_ready && n < 12) begin
            tick();
            n++;
        end
        if (!alu_input_ready) begin
            check_output("issue_seen", {15'h0, alu_input_ready}, 16'h1);
            return;
        end
        if (q.size() == 0) begin
            check_output("issue_unexpected", {15'h0, alu_input_ready}, 16'h0);
            return;
        end
        ins = q.pop_front();
        op  = ins[15:11];
        rd  = ins[10:8];
        ra  = ins[7:5];
        rb  = ins[4:2];
        a   = ref_regs[ra];
        b   = ref_regs[rb];
        cin = ins[1] & ref_flags[0];
        bin = ins[0] & ref_flags[1];
        check_output("opcode", {11'h0, alu_opcode}, {11'h0, op});
        check_output("operand_A", {8'h0, alu_operand_A}, {8'h0, a});
        check_output("operand_B", {8'h0, alu_operand_B}, {8'h0, b});
        check_output("carry_in", {15'h0, alu_carry_in}, {15'h0, cin});
        check_output("borrow_in", {15'h0, alu_borrow_in}, {15'h0, bin});
        m = alu_model(op, a, b, cin, bin);
        if (ra_write) begin
            wr_en   = 1'b1;
            wr_addr = ra;
            wr_data = ~a;
            ref_regs[ra] = ~a;
        end
        tick();
        wr_en = 1'b0;
        check_output("input_ready_pulse", {15'h0, alu_input_ready}, 16'h0);
        check_output("busy_wait", {15'h0, busy}, 16'h1);
        if (expect_to) begin
            for (int i = 1; i <= TIMEOUT; i++) begin
                if (i == TIMEOUT) begin
                    check_output("timeout_not_early", {15'h0, timeout_err}, {15'h0, ref_timeout});
                end
                drive_push();
                tick();
            end
            instr_valid = 1'b0;
            check_output("timeout_set", {15'h0, timeout_err}, 16'h1);
            ref_timeout = 1'b1;
        end else begin
            for (int i = 1; i <= k; i++) begin
                check_output("operand_A_hold", {8'h0, alu_operand_A}, {8'h0, a});
                drive_push();
                if (i == k) begin
                    alu_result_ready = 1'b1;
                    alu_result       = m[7:0];
                    alu_carry_out    = m[8];
                    alu_borrow_out   = m[9];
                    alu_zero         = m[10];
                    alu_negative     = m[11];
                    alu_overflow     = m[12];
                end
                tick();
            end
            instr_valid      = 1'b0;
            alu_result_ready = 1'b0;
            alu_result       = 8'($urandom);
            {alu_overflow, alu_negative, alu_zero, alu_borrow_out, alu_carry_out} = 5'($urandom);
            if (collide) begin
                wr_en   = 1'b1;
                wr_addr = rd;
                wr_data = ~m[7:0];
            end
            tick();
            wr_en = 1'b0;
            ref_regs[rd] = m[7:0];
            ref_flags    = m[12:8];
        end
    endtask

    initial begin
        instr_valid      = 1'b0;
        instr_data       = 16'h0;
        wr_en            = 1'b0;
        wr_addr          = 3'h0;
        wr_data          = 8'h0;
        rd_addr          = 3'h0;
        alu_result       = 8'h0;
        alu_result_ready = 1'b0;
        alu_carry_out    = 1'b0;
        alu_borrow_out   = 1'b0;
        alu_zero         = 1'b0;
        alu_negative     = 1'b0;
        alu_overflow     = 1'b0;
        model_reset();

        // Reset values
        rst = 1'b0;
        tick();
        check_output("rst_instr_ready", {15'h0, instr_ready}, 16'h1);
        check_output("rst_input_ready", {15'h0, alu_input_ready}, 16'h0);
        check_output("rst_opcode", {11'h0, alu_opcode}, 16'h0);
        check_output("rst_opA", {8'h0, alu_operand_A}, 16'h0);
        check_output("rst_opB", {8'h0, alu_operand_B}, 16'h0);
        check_output("rst_busy", {15'h0, busy}, 16'h0);
        check_output("rst_enable", {15'h0, alu_enable}, 16'h0);
        rst = 1'b1;
        tick();
        check_output("enable_on", {15'h0, alu_enable}, 16'h1);
        check_regs("reset");

        // Simple add: -84 + 68 = -16, with issue latency check
        preload(3'd1, 8'hAC);
        preload(3'd2, 8'h44);
        push_now(mk(5'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0));
        check_output("busy_pending", {15'h0, busy}, 16'h1);
        tick();
        check_output("issue_latency", {15'h0, alu_input_ready}, 16'h1);
        apply_stimulus(2, 1'b0, 1'b0, 1'b0);
        rd_addr = 3'd3;
        #1;
        check_output("simple_add_r3", {8'h0, rd_data}, 16'h00F0);
        check_output("simple_add_neg", {15'h0, flags[3]}, 16'h1);
        check_regs("simple_add");

        // Carry chain
        preload(3'd1, 8'hFF);
        preload(3'd2, 8'h01);
        push_now(mk(5'd0, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0));
        apply_stimulus(1, 1'b0, 1'b0, 1'b0);
        check_output("carry_flags", {11'h0, flags}, 16'h0005);
        push_now(mk(5'd0, 3'd5, 3'd1, 3'd2, 1'b1, 1'b0));
        tick();
        check_output("carry_chain_cin1", {15'h0, alu_carry_in}, 16'h1);
        apply_stimulus(3, 1'b0, 1'b0, 1'b0);
        push_now(mk(5'd0, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0));
        tick();
        check_output("carry_chain_cin0", {15'h0, alu_carry_in}, 16'h0);
        apply_stimulus(1, 1'b0, 1'b0, 1'b0);
        check_regs("carry");

        // FIFO full: DEPTH+2 offers while the ALU stalls an earlier instruction
        push_now(mk(5'd2, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0));
        for (int j = 0; j < DEPTH + 2; j++) begin
            pend.push_back(mk(5'(3 + j), 3'(j), 3'(j + 1), 3'(j + 2), 1'b0, 1'b0));
        end
        apply_stimulus(8, 1'b0, 1'b0, 1'b0);
        check_output("fifo_full_ready", {15'h0, instr_ready}, 16'h0);
        for (int j = 0; j < DEPTH; j++) begin
            apply_stimulus(1 + (j % 3), 1'b0, 1'b0, 1'b0);
        end
        check_output("fifo_drained_busy", {15'h0, busy}, 16'h0);
        check_regs("fifo");

        // Timeout, then the next instruction still issues
        push_now(mk(5'd0, 3'd3, 3'd4, 3'd5, 1'b0, 1'b0));
        apply_stimulus(0, 1'b1, 1'b0, 1'b0);
        check_regs("timeout");
        push_now(mk(5'd1, 3'd3, 3'd4, 3'd5, 1'b0, 1'b1));
        apply_stimulus(2, 1'b0, 1'b0, 1'b0);
        check_regs("after_timeout");

        // Host write collides with WB; host overwrite of ra after the pop
        push_now(mk(5'd1, 3'd2, 3'd3, 3'd4, 1'b0, 1'b1));
        apply_stimulus(2, 1'b0, 1'b1, 1'b1);
        check_regs("collide");

        // Randomized instructions
        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) == 1) preload(3'($urandom), 8'($urandom));
            push_now(mk(5'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 3'($urandom),
                        1'($urandom), 1'($urandom)));
            apply_stimulus(int'($urandom_range(1, 4)), 1'b0, 1'($urandom), 1'($urandom));
            check_regs("rand");
        end

        // Reset asserted mid-WAIT aborts without writeback
        preload(3'd2, 8'h11);
        push_now(mk(5'd0, 3'd1, 3'd2, 3'd2, 1'b0, 1'b0));
        tick();
        check_output("mid_issue", {15'h0, alu_input_ready}, 16'h1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_output("mid_rst_busy", {15'h0, busy}, 16'h0);
        check_output("mid_rst_ready", {15'h0, instr_ready}, 16'h1);
        check_output("mid_rst_opcode", {11'h0, alu_opcode}, 16'h0);
        model_reset();
        tick();
        rst = 1'b1;
        alu_result_ready = 1'b1;
        alu_result       = 8'h5A;
        tick();
        alu_result_ready = 1'b0;
        tick();
        check_output("post_rst_busy", {15'h0, busy}, 16'h0);
        check_regs("mid_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
